// File: rtl/hall_commutator_pkg.sv
// fc_pkg: shared types, Hall code constants and decode/commutation helpers.
package fc_pkg;
  typedef logic [2:0] sector_t;
  typedef enum logic [1:0] {IDLE, ACQUIRE, RUN, FAULT} state_t;
  localparam logic [2:0] HALL_INV0 = 3'b000;
  localparam logic [2:0] HALL_INV1 = 3'b111;
  function automatic sector_t hall_to_sector(input logic [2:0] h);
    return h == 3'b001 ? 3'd0 : h == 3'b011 ? 3'd1 : h == 3'b010 ? 3'd2 :
           h == 3'b110 ? 3'd3 : h == 3'b100 ? 3'd4 : h == 3'b101 ? 3'd5 : 3'd7;
  endfunction
  // Reverse drive is the forward pattern shifted by half a revolution.
  function automatic logic [5:0] sector_to_status(input sector_t s, input logic rev);
    sector_t e;
    e = !rev ? s : (s >= 3'd3 ? s - 3'd3 : s + 3'd3);
    return e == 3'd0 ? 6'b100100 : e == 3'd1 ? 6'b100001 : e == 3'd2 ? 6'b001001 :
           e == 3'd3 ? 6'b011000 : e == 3'd4 ? 6'b010010 : e == 3'd5 ? 6'b000110 : 6'b000000;
  endfunction
endpackage

// File: rtl/hall_commutator_filter.sv
// hall_filter: 2-FF synchronizer plus debounce; strobes new_code_o when a stable code is accepted.
module hall_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] hall_i,
  output logic [2:0] code_o,
  output logic       new_code_o,
  output logic       valid_o
);
  localparam logic [7:0] F = 8'(FILT_LEN);
  logic [2:0] s1, s2;
  logic [7:0] cnt;
  logic       acc;
  // cnt holds the number of cycles s2 has kept its current value
  assign acc = cnt == F && (s2 != code_o || !valid_o);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1 <= '0;
      s2 <= '0;
      cnt <= '0;
      code_o <= '0;
      new_code_o <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      s1 <= hall_i;
      s2 <= s1;
      cnt <= s1 != s2 ? 8'd1 : (cnt == F ? cnt : cnt + 8'd1);
      new_code_o <= acc;
      if (acc) begin
        code_o <= s2;
        valid_o <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/hall_commutator.sv
// hall_commutator: Hall sensor decode to six-step commutation with direction, period, fault and stall.
module hall_commutator
  import fc_pkg::*;
#(
  parameter int FILT_LEN     = 4,
  parameter int PERIOD_W     = 16,
  parameter int STALL_CYCLES = 50000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [2:0]          hall_i,
  input  logic                ena_i,
  input  logic                dir_i,
  output logic [5:0]          status_o,
  output logic [2:0]          sector_o,
  output logic                dir_o,
  output logic [PERIOD_W-1:0] period_o,
  output logic                period_valid_o,
  output logic                fault_o,
  output logic                stall_o
);
  localparam logic [PERIOD_W-1:0] STALL = PERIOD_W'(STALL_CYCLES);
  logic [2:0]          code;
  logic                new_code, code_vld, bad, up, dn, armed;
  sector_t             ns;
  state_t              state;
  logic [PERIOD_W-1:0] cnt, cnt_inc;
  hall_filter #(.FILT_LEN(FILT_LEN)) u_filt (
    .clk_i(clk_i), .rst_i(rst_i), .hall_i(hall_i),
    .code_o(code), .new_code_o(new_code), .valid_o(code_vld)
  );
  assign ns = hall_to_sector(code);
  assign bad = code == HALL_INV0 || code == HALL_INV1;
  assign up = ns == (sector_o == 3'd5 ? 3'd0 : sector_o + 3'd1);
  assign dn = ns == (sector_o == 3'd0 ? 3'd5 : sector_o - 3'd1);
  assign cnt_inc = &cnt ? cnt : cnt + PERIOD_W'(1);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      status_o <= '0;
      sector_o <= '0;
      dir_o <= 1'b0;
      period_o <= '0;
      period_valid_o <= 1'b0;
      fault_o <= 1'b0;
      stall_o <= 1'b0;
      cnt <= '0;
      armed <= 1'b0;
    end else begin
      period_valid_o <= 1'b0;
      if (!ena_i) begin
        state <= IDLE;
        status_o <= '0;
        fault_o <= 1'b0;
        stall_o <= 1'b0;
        cnt <= '0;
        armed <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            status_o <= '0;
            state <= ACQUIRE;
          end
          ACQUIRE: begin
            status_o <= '0;
            if (code_vld && bad) begin
              state <= FAULT;
              fault_o <= 1'b1;
            end else if (code_vld) begin
              state <= RUN;
              sector_o <= ns;
              status_o <= sector_to_status(ns, dir_i);
            end
          end
          RUN: begin
            if (new_code && (bad || !(up || dn))) begin
              state <= FAULT;
              status_o <= '0;
              fault_o <= 1'b1;
            end else if (new_code) begin
              sector_o <= ns;
              dir_o <= dn;
              status_o <= sector_to_status(ns, dir_i);
              // the counter is only trustworthy once armed by a prior transition and not stalled
              if (armed && !stall_o) begin
                period_o <= cnt;
                period_valid_o <= 1'b1;
              end
              cnt <= PERIOD_W'(1);
              armed <= 1'b1;
              stall_o <= 1'b0;
            end else begin
              status_o <= sector_to_status(sector_o, dir_i);
              cnt <= cnt_inc;
              if (cnt_inc >= STALL) stall_o <= 1'b1;
            end
          end
          FAULT: begin
            status_o <= '0;
            fault_o <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hall_commutator.sv
// tb_hall_commutator: randomized self-checking bench against a timing-level behavioural model.
module tb_hall_commutator;
  localparam int F = 4;
  localparam int STALL = 50000;
  logic clk = 1'b0, rst = 1'b1, ena = 1'b0, dir = 1'b0;
  logic [2:0] hall = 3'b001;
  logic [5:0] status_o;
  logic [2:0] sector_o;
  logic dir_o, period_valid_o, fault_o, stall_o;
  logic [15:0] period_o;
  logic [2:0] CODE [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
  logic [5:0] ST [6] = '{6'b100100, 6'b100001, 6'b001001, 6'b011000, 6'b010010, 6'b000110};
  int cyc = 0, pass = 0, total = 0;
  int m_sec, m_last;
  logic m_dir, m_armed, m_stall;

  hall_commutator #(.FILT_LEN(F), .PERIOD_W(16), .STALL_CYCLES(STALL)) dut (
    .clk_i(clk), .rst_i(rst), .hall_i(hall), .ena_i(ena), .dir_i(dir),
    .status_o(status_o), .sector_o(sector_o), .dir_o(dir_o), .period_o(period_o),
    .period_valid_o(period_valid_o), .fault_o(fault_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] pat(input int s, input logic d);
    return ST[d ? (s + 3) % 6 : s];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a new code, check latency, outputs and period, then hold until dur cycles after the drive.
  task automatic move(input int s, input int dur);
    int t;
    logic ed, epv;
    ed = (s != (m_sec + 1) % 6);
    epv = m_armed && !m_stall;
    hall = CODE[s];
    t = cyc;
    tick(2 + F);
    total++; if (sector_o !== 3'(m_sec)) $display("FAIL move_early sector=%0d want %0d", sector_o, m_sec); else pass++;
    tick(1);
    total++; if (sector_o !== 3'(s)) $display("FAIL move_sector got %0d want %0d", sector_o, s); else pass++;
    total++; if (status_o !== pat(s, dir)) $display("FAIL move_status got %b want %b", status_o, pat(s, dir)); else pass++;
    total++; if (dir_o !== ed) $display("FAIL move_dir got %b want %b", dir_o, ed); else pass++;
    total++; if (period_valid_o !== epv) $display("FAIL move_pv got %b want %b", period_valid_o, epv); else pass++;
    if (epv) begin
      total++; if (period_o !== 16'(t - m_last)) $display("FAIL move_period got %0d want %0d", period_o, t - m_last); else pass++;
    end
    total++; if (stall_o !== 1'b0) $display("FAIL move_stall got %b want 0", stall_o); else pass++;
    m_sec = s; m_dir = ed; m_last = t; m_armed = 1'b1; m_stall = 1'b0;
    tick(1);
    total++; if (period_valid_o !== 1'b0) $display("FAIL pv_pulse got %b want 0", period_valid_o); else pass++;
    tick(dur - (4 + F));
  endtask

  task automatic test_reset;
    rst = 1'b1; ena = 1'b0; dir = 1'b0; hall = 3'b001;
    tick(3);
    total++; if (status_o !== 6'd0) $display("FAIL rst_status got %b want 0", status_o); else pass++;
    total++; if (sector_o !== 3'd0) $display("FAIL rst_sector got %0d want 0", sector_o); else pass++;
    total++; if (dir_o !== 1'b0) $display("FAIL rst_dir got %b want 0", dir_o); else pass++;
    total++; if (period_o !== 16'd0) $display("FAIL rst_period got %0d want 0", period_o); else pass++;
    total++; if ({period_valid_o, fault_o, stall_o} !== 3'b000) $display("FAIL rst_flags got %b want 000", {period_valid_o, fault_o, stall_o}); else pass++;
    rst = 1'b0;
    tick(1);
  endtask

  task automatic acquire(input int s);
    ena = 1'b1;
    tick(2 * F + 10);
    total++; if (sector_o !== 3'(s)) $display("FAIL acq_sector got %0d want %0d", sector_o, s); else pass++;
    total++; if (status_o !== pat(s, dir)) $display("FAIL acq_status got %b want %b", status_o, pat(s, dir)); else pass++;
    total++; if ({period_valid_o, fault_o} !== 2'b00) $display("FAIL acq_flags got %b want 00", {period_valid_o, fault_o}); else pass++;
    m_sec = s; m_armed = 1'b0; m_stall = 1'b0; m_last = cyc;
  endtask

  task automatic test_forward;
    acquire(0);
    for (int k = 0; k < 6; k++) move((m_sec + 1) % 6, $urandom_range(300, 1200));
  endtask

  task automatic test_reverse;
    dir = 1'b1;
    tick(1);
    total++; if (status_o !== 6'b011000) $display("FAIL rev_status got %b want 011000", status_o); else pass++;
    for (int k = 0; k < 6; k++) move((m_sec + 5) % 6, $urandom_range(200, 900));
    for (int k = 0; k < 6; k++) begin
      dir = 1'($urandom_range(0, 1));
      tick(1);
      total++; if (status_o !== pat(m_sec, dir)) $display("FAIL dir_follow got %b want %b", status_o, pat(m_sec, dir)); else pass++;
      move($urandom_range(0, 1) ? (m_sec + 1) % 6 : (m_sec + 5) % 6, $urandom_range(100, 600));
    end
  endtask

  task automatic test_glitch;
    int len;
    logic [10:0] exp_snap;
    len = $urandom_range(1, F - 1);
    exp_snap = {pat(m_sec, dir), 3'(m_sec), m_dir, 1'b0};
    hall = CODE[(m_sec + 1) % 6];
    tick(len);
    hall = CODE[m_sec];
    for (int k = 0; k < 12; k++) begin
      tick(1);
      total++;
      if ({status_o, sector_o, dir_o, period_valid_o | fault_o} !== exp_snap)
        $display("FAIL glitch got %b want %b", {status_o, sector_o, dir_o, period_valid_o | fault_o}, exp_snap);
      else pass++;
    end
    tick(20);
    move((m_sec + 1) % 6, 400);
  endtask

  task automatic test_stall;
    int target;
    logic [5:0] st;
    target = m_last + 3 + F + STALL - 2;
    while (cyc < target) tick(1);
    total++; if (stall_o !== 1'b0) $display("FAIL stall_early got %b want 0", stall_o); else pass++;
    tick(1);
    st = pat(m_sec, dir);
    total++; if (stall_o !== 1'b1) $display("FAIL stall_set got %b want 1", stall_o); else pass++;
    total++; if (status_o !== st) $display("FAIL stall_status got %b want %b", status_o, st); else pass++;
    m_stall = 1'b1;
    tick(5);
    move((m_sec + 1) % 6, 500);
    move((m_sec + 1) % 6, $urandom_range(300, 700));
  endtask

  task automatic test_fault;
    logic [2:0] bc;
    int t, r;
    for (int kind = 0; kind < 4; kind++) begin
      bc = kind == 0 ? CODE[(m_sec + 3) % 6] : kind == 1 ? CODE[(m_sec + 2 + 2 * $urandom_range(0, 1)) % 6] :
           kind == 2 ? 3'b111 : 3'b000;
      hall = bc;
      t = cyc;
      tick(2 + F);
      total++; if (fault_o !== 1'b0) $display("FAIL fault_early kind%0d got %b want 0", kind, fault_o); else pass++;
      tick(1);
      total++; if (fault_o !== 1'b1) $display("FAIL fault_set kind%0d got %b want 1", kind, fault_o); else pass++;
      total++; if (status_o !== 6'd0) $display("FAIL fault_status kind%0d got %b want 0", kind, status_o); else pass++;
      tick(3);
      total++; if ({fault_o, status_o} !== 7'b1000000) $display("FAIL fault_hold kind%0d got %b want 1000000", kind, {fault_o, status_o}); else pass++;
      ena = 1'b0;
      r = $urandom_range(0, 5);
      hall = CODE[r];
      tick(1);
      total++; if ({fault_o, stall_o, status_o} !== 8'd0) $display("FAIL fault_clear kind%0d got %b want 0", kind, {fault_o, stall_o, status_o}); else pass++;
      tick(F + 6);
      acquire(r);
      move($urandom_range(0, 1) ? (m_sec + 1) % 6 : (m_sec + 5) % 6, 200);
    end
  endtask

  task automatic test_reset_mid;
    move((m_sec + 1) % 6, 300);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    total++;
    if ({status_o, sector_o, dir_o, period_o, period_valid_o, fault_o, stall_o} !== 29'd0)
      $display("FAIL reset_mid got %h want 0", {status_o, sector_o, dir_o, period_o, period_valid_o, fault_o, stall_o});
    else pass++;
    tick(2);
    total++; if (status_o !== 6'd0) $display("FAIL reset_idle_status got %b want 0", status_o); else pass++;
  endtask

  initial begin
    test_reset;
    dir = 1'b0;
    test_forward;
    test_reverse;
    test_glitch;
    test_stall;
    test_fault;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
